// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI engine arbiter.
// SPI_ARB_TIMEOUT_EN (optional define) adds a WAIT-state watchdog and an err_o port.
package spi_arb_pkg;

    localparam int MAX_NREQ     = 8;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_GAP   = 4;
    localparam int DEF_TIMEOUT  = 255;

    // state     | meaning
    // ST_IDLE   | no owner, waiting for any request
    // ST_SETUP  | owner selected, chip select low before first byte
    // ST_START  | one-cycle start pulse to the shift engine
    // ST_WAIT   | engine shifting, waiting for eng_done
    // ST_ACK    | received byte presented to the owner for one cycle
    // ST_GAP    | chip select high between transactions
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_ACK,
        ST_GAP
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module spi_arb_rr
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    // Scan NREQ candidates starting at ptr_i; the first one requesting wins.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                win_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin owner of a shared SPI byte engine; holds the owner's chip select
// for a whole multi-byte transaction and hands back each received byte.
// Optional define SPI_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and adds err_o.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_GAP   = DEF_CS_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   last_i,
    input  logic [8*NREQ-1:0] dat_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   ack_o,
    output logic [7:0]        rdat_o,
    output logic [NREQ-1:0]   spi_cs_n,
    output logic              eng_start,
    output logic [7:0]        eng_dat_o,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic              err_o,
`endif
    input  logic              eng_done,
    input  logic [7:0]        eng_rdat_i
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(max3(CS_SETUP, CS_GAP, TIMEOUT) + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   own_oh_q, own_oh_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              last_q, last_d;
    logic [7:0]        eng_dat_q, eng_dat_d;
    logic [7:0]        rdat_q, rdat_d;

    logic [NREQ-1:0]   pick_win;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              req_own;
    logic              last_own;
    logic [7:0]        dat_own;

    assign req_own  = req_i[owner_q];
    assign last_own = last_i[owner_q];
    assign dat_own  = dat_i[{owner_q, 3'b000} +: 8];

    spi_arb_rr #(.NREQ(NREQ)) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= '0;
            own_oh_q  <= '0;
            ptr_q     <= '0;
            last_q    <= 1'b0;
            eng_dat_q <= 8'h00;
            rdat_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            own_oh_q  <= own_oh_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            eng_dat_q <= eng_dat_d;
            rdat_q    <= rdat_d;
        end
    end

    // Next-state logic; one down-counter times SETUP, GAP and (optionally) WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        own_oh_d  = own_oh_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        eng_dat_d = eng_dat_q;
        rdat_d    = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d  = pick_idx;
                    own_oh_d = pick_win;
                    ptr_d    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    cnt_d    = CNT_W'(CS_SETUP - 1);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!req_own) begin
                    cnt_d   = CNT_W'(CS_GAP - 1);
                    state_d = ST_GAP;
                end else if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_START: begin
                eng_dat_d = dat_own;
                last_d    = last_own;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d     = CNT_W'(TIMEOUT);
`endif
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    rdat_d  = eng_rdat_i;
                    state_d = ST_ACK;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(CS_GAP - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            ST_ACK: begin
                if (last_q || !req_own) begin
                    cnt_d   = CNT_W'(CS_GAP - 1);
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the start byte passes straight through so it is valid with eng_start.
    always_comb begin
        gnt_o     = '0;
        ack_o     = '0;
        spi_cs_n  = '1;
        eng_start = 1'b0;
        eng_dat_o = eng_dat_q;
        rdat_o    = rdat_q;
        case (state_q)
            ST_SETUP, ST_WAIT: gnt_o = own_oh_q;
            ST_START: begin
                gnt_o     = own_oh_q;
                eng_start = 1'b1;
                eng_dat_o = dat_own;
            end
            ST_ACK: begin
                gnt_o = own_oh_q;
                ack_o = own_oh_q;
            end
            default: gnt_o = '0;
        endcase
        spi_cs_n = ~gnt_o;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog fires in the WAIT cycle where the count has expired and no byte arrived.
    assign err_o = (state_q == ST_WAIT) && !eng_done && (cnt_q == '0);
`endif

endmodule

// File: tb/tb_spi_arb.sv
// Directed self-checking bench for spi_arb (NREQ=4, CS_SETUP=2, CS_GAP=4, TIMEOUT=20).
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  last_i = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  gnt_o, ack_o, spi_cs_n;
    logic [7:0]  rdat_o, eng_dat_o;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rdat_i = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        err_o;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_arb #(.NREQ(4), .CS_SETUP(2), .CS_GAP(4), .TIMEOUT(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .last_i     (last_i),
        .dat_i      (dat_i),
        .gnt_o      (gnt_o),
        .ack_o      (ack_o),
        .rdat_o     (rdat_o),
        .spi_cs_n   (spi_cs_n),
        .eng_start  (eng_start),
        .eng_dat_o  (eng_dat_o),
`ifdef SPI_ARB_TIMEOUT_EN
        .err_o      (err_o),
`endif
        .eng_done   (eng_done),
        .eng_rdat_i (eng_rdat_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until eng_start is seen; cyc = ticks taken, -1 if the budget ran out.
    task automatic wait_start(input int max, output int cyc);
        cyc = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (eng_start === 1'b1) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    // Called in a START cycle; pulses eng_done lat cycles later and returns in the ACK cycle.
    task automatic engine_reply(input int lat, input logic [7:0] rx);
        tick_n(lat);
        eng_done = 1'b1;
        eng_rdat_i = rx;
        tick();
        eng_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_n(3);
        reset = 1'b0;
        tick();
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt_o, 4'b0000); end
        total++; if (ack_o !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=%b", ack_o, 4'b0000); end
        total++; if (spi_cs_n !== 4'b1111) begin bad++; $display("FAIL reset_cs got=%b exp=%b", spi_cs_n, 4'b1111); end
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", eng_start); end
        total++; if (eng_dat_o !== 8'h00 || rdat_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h/%h exp=00/00", eng_dat_o, rdat_o); end
    endtask

    task automatic test_single();
        logic ok;
        req_i = 4'b0010; last_i = 4'b0010; dat_i = 32'h0000_A500;
        tick();
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL single_gnt got=%b exp=%b", gnt_o, 4'b0010); end
        total++; if (spi_cs_n !== 4'b1101) begin bad++; $display("FAIL single_cs_setup got=%b exp=%b", spi_cs_n, 4'b1101); end
        tick();
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_early_start got=%b exp=0", eng_start); end
        tick();
        total++; if (eng_start !== 1'b1 || eng_dat_o !== 8'hA5) begin bad++; $display("FAIL single_start got=%b/%h exp=1/a5", eng_start, eng_dat_o); end
        ok = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (eng_start !== 1'b0 || spi_cs_n !== 4'b1101 || ack_o !== 4'b0000) ok = 1'b0;
        end
        tick();
        eng_done = 1'b1; eng_rdat_i = 8'h3C;
        tick();
        eng_done = 1'b0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_wait_hold got=%b exp=1", ok); end
        total++; if (ack_o !== 4'b0010 || rdat_o !== 8'h3C) begin bad++; $display("FAIL single_ack got=%b/%h exp=0010/3c", ack_o, rdat_o); end
        total++; if (spi_cs_n !== 4'b1101) begin bad++; $display("FAIL single_cs_ack got=%b exp=%b", spi_cs_n, 4'b1101); end
        req_i = 4'b0000;
        tick();
        total++; if (spi_cs_n !== 4'b1111 || gnt_o !== 4'b0000 || ack_o !== 4'b0000) begin bad++; $display("FAIL single_gap got=%b/%b/%b exp=1111/0000/0000", spi_cs_n, gnt_o, ack_o); end
        tick_n(3);
        req_i = 4'b0010;
        tick();
        total++; if (spi_cs_n !== 4'b1111) begin bad++; $display("FAIL gap_len_idle got=%b exp=%b", spi_cs_n, 4'b1111); end
        tick();
        total++; if (spi_cs_n !== 4'b1101) begin bad++; $display("FAIL gap_len_regrant got=%b exp=%b", spi_cs_n, 4'b1101); end
        req_i = 4'b0000;
        tick();
        total++; if (spi_cs_n !== 4'b1111) begin bad++; $display("FAIL setup_abort_cs got=%b exp=%b", spi_cs_n, 4'b1111); end
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (eng_start !== 1'b0 || spi_cs_n !== 4'b1111) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL setup_abort_nostart got=%b exp=1", ok); end
        last_i = '0; dat_i = '0;
    endtask

    task automatic test_multi();
        logic [7:0] rx [3];
        logic ok;
        rx[0] = 8'h11; rx[1] = 8'h22; rx[2] = 8'h33;
        req_i = 4'b0001; last_i = 4'b0000; dat_i = 32'h0000_009F;
        tick_n(3);
        total++; if (eng_start !== 1'b1 || eng_dat_o !== 8'h9F) begin bad++; $display("FAIL multi_start0 got=%b/%h exp=1/9f", eng_start, eng_dat_o); end
        for (int b = 0; b < 3; b++) begin
            ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (spi_cs_n !== 4'b1110 || ack_o !== 4'b0000 || eng_start !== 1'b0) ok = 1'b0;
            end
            eng_done = 1'b1; eng_rdat_i = rx[b];
            tick();
            eng_done = 1'b0;
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL multi_wait_hold byte=%0d got=%b exp=1", b, ok); end
            total++; if (ack_o !== 4'b0001 || rdat_o !== rx[b]) begin bad++; $display("FAIL multi_ack byte=%0d got=%b/%h exp=0001/%h", b, ack_o, rdat_o, rx[b]); end
            if (b < 2) begin
                dat_i = 32'h0000_0000;
                last_i = (b == 1) ? 4'b0001 : 4'b0000;
                tick();
                total++; if (eng_start !== 1'b1 || eng_dat_o !== 8'h00 || spi_cs_n !== 4'b1110) begin bad++; $display("FAIL multi_next_start byte=%0d got=%b/%h/%b exp=1/00/1110", b + 1, eng_start, eng_dat_o, spi_cs_n); end
            end else begin
                req_i = 4'b0000;
                tick();
                total++; if (spi_cs_n !== 4'b1111) begin bad++; $display("FAIL multi_release got=%b exp=%b", spi_cs_n, 4'b1111); end
            end
        end
        last_i = '0;
        tick_n(6);
    endtask

    task automatic test_reset_wait();
        int c;
        req_i = 4'b0100; last_i = 4'b0100; dat_i = 32'h0055_0000;
        wait_start(10, c);
        total++; if (c !== 3) begin bad++; $display("FAIL rst_start_latency got=%0d exp=3", c); end
        tick_n(3);
        reset = 1'b1; req_i = 4'b0000;
        tick();
        reset = 1'b0;
        total++; if (spi_cs_n !== 4'b1111 || gnt_o !== 4'b0000) begin bad++; $display("FAIL rst_mid_outputs got=%b/%b exp=1111/0000", spi_cs_n, gnt_o); end
        total++; if (eng_dat_o !== 8'h00 || eng_start !== 1'b0) begin bad++; $display("FAIL rst_mid_eng got=%h/%b exp=00/0", eng_dat_o, eng_start); end
        eng_done = 1'b1; eng_rdat_i = 8'hEE;
        tick();
        eng_done = 1'b0;
        total++; if (ack_o !== 4'b0000 || rdat_o !== 8'h00 || spi_cs_n !== 4'b1111) begin bad++; $display("FAIL rst_stray_done got=%b/%h/%b exp=0000/00/1111", ack_o, rdat_o, spi_cs_n); end
        last_i = '0; dat_i = '0;
        tick_n(2);
    endtask

    task automatic test_rr();
        int exp_ord [5];
        int c;
        logic ok;
        logic [3:0] e;
        exp_ord[0] = 0; exp_ord[1] = 2; exp_ord[2] = 3; exp_ord[3] = 0; exp_ord[4] = 2;
        req_i = 4'b1101; last_i = 4'b1101; dat_i = 32'hD3C2_B1A0;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << exp_ord[k];
            c = -1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (!$onehot0(gnt_o) || !$onehot0(ack_o) || !$onehot0(~spi_cs_n)) ok = 1'b0;
                if (eng_start === 1'b1) begin
                    c = i;
                    break;
                end
            end
            total++; if (c < 0) begin bad++; $display("FAIL rr_timeout grant=%0d got=none exp=start", k); end
            total++; if (gnt_o !== e || eng_dat_o !== dat_i[8*exp_ord[k] +: 8]) begin bad++; $display("FAIL rr_grant idx=%0d got=%b/%h exp=%b/%h", k, gnt_o, eng_dat_o, e, dat_i[8*exp_ord[k] +: 8]); end
            engine_reply(3, 8'h80 + 8'(k));
            total++; if (ack_o !== e || rdat_o !== 8'h80 + 8'(k)) begin bad++; $display("FAIL rr_ack idx=%0d got=%b/%h exp=%b/%h", k, ack_o, rdat_o, e, 8'h80 + 8'(k)); end
            if (k == 4) req_i = 4'b0000;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_exclusive got=%b exp=1", ok); end
        last_i = '0; dat_i = '0;
        tick_n(8);
    endtask

    task automatic test_drop();
        int c;
        req_i = 4'b1010; last_i = 4'b0000; dat_i = 32'h7700_1100;
        wait_start(10, c);
        total++; if (c !== 3 || gnt_o !== 4'b1000 || eng_dat_o !== 8'h77) begin bad++; $display("FAIL drop_first got=%0d/%b/%h exp=3/1000/77", c, gnt_o, eng_dat_o); end
        engine_reply(4, 8'h42);
        total++; if (ack_o !== 4'b1000 || rdat_o !== 8'h42) begin bad++; $display("FAIL drop_ack got=%b/%h exp=1000/42", ack_o, rdat_o); end
        req_i = 4'b0010; last_i = 4'b0010;
        tick();
        total++; if (spi_cs_n !== 4'b1111 || eng_start !== 1'b0) begin bad++; $display("FAIL drop_gap got=%b/%b exp=1111/0", spi_cs_n, eng_start); end
        wait_start(20, c);
        total++; if (c !== 7) begin bad++; $display("FAIL drop_next_latency got=%0d exp=7", c); end
        total++; if (gnt_o !== 4'b0010 || eng_dat_o !== 8'h11) begin bad++; $display("FAIL drop_next_grant got=%b/%h exp=0010/11", gnt_o, eng_dat_o); end
        engine_reply(2, 8'h5A);
        total++; if (ack_o !== 4'b0010 || rdat_o !== 8'h5A) begin bad++; $display("FAIL drop_next_ack got=%b/%h exp=0010/5a", ack_o, rdat_o); end
        req_i = 4'b0000; last_i = '0; dat_i = '0;
        tick_n(8);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        logic ok;
        req_i = 4'b0001; last_i = 4'b0001; dat_i = 32'h0000_00C7;
        wait_start(10, c);
        total++; if (c !== 3) begin bad++; $display("FAIL to_start got=%0d exp=3", c); end
        ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (err_o !== 1'b0 || ack_o !== 4'b0000) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_early_err got=%b exp=1", ok); end
        tick();
        total++; if (err_o !== 1'b1 || ack_o !== 4'b0000) begin bad++; $display("FAIL to_err_pulse got=%b/%b exp=1/0000", err_o, ack_o); end
        tick();
        total++; if (err_o !== 1'b0 || spi_cs_n !== 4'b1111) begin bad++; $display("FAIL to_release got=%b/%b exp=0/1111", err_o, spi_cs_n); end
        req_i = 4'b0000; last_i = '0; dat_i = '0;
        tick_n(8);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_reset_wait();
        test_rr();
        test_drop();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
